// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline stage: ALU op codes,
// datapath widths, the EX register layout and its bubble value.
package id_ex_stage_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_NONE = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs_val;
    logic [XLEN-1:0]    rt_val;
    logic [XLEN-1:0]    imm;
    logic [4:0]         shamt;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] rd;
    logic [3:0]         alu_op;
    logic               use_imm;
    logic               use_shamt;
    ctrl_t              ctrl;
  } ex_reg_t;

  localparam ex_reg_t EX_BUBBLE = '{alu_op: ALU_NONE, ctrl: CTRL_BUBBLE, default: '0};

  // A writer hits a source when it writes back a non-zero register equal to it.
  function automatic logic writer_hits(input logic               reg_write,
                                       input logic [RADDR_W-1:0] rd,
                                       input logic [RADDR_W-1:0] src);
    return reg_write && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Port bundle between ID, the forwarding sources and the ID/EX stage.
// The stage uses the slave modport; the driving side uses master.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic               stall_i;
  logic               flush_i;
  logic               id_valid_i;
  logic [XLEN-1:0]    id_pc_i;
  logic [XLEN-1:0]    id_rs_val_i;
  logic [XLEN-1:0]    id_rt_val_i;
  logic [XLEN-1:0]    id_imm_i;
  logic [4:0]         id_shamt_i;
  logic [RADDR_W-1:0] id_rs_i;
  logic [RADDR_W-1:0] id_rt_i;
  logic [RADDR_W-1:0] id_rd_i;
  logic [3:0]         id_alu_op_i;
  logic               id_use_imm_i;
  logic               id_use_shamt_i;
  logic               id_reg_write_i;
  logic               id_mem_read_i;
  logic               id_mem_write_i;
  logic               exmem_reg_write_i;
  logic [RADDR_W-1:0] exmem_rd_i;
  logic [XLEN-1:0]    exmem_result_i;
  logic               memwb_reg_write_i;
  logic [RADDR_W-1:0] memwb_rd_i;
  logic [XLEN-1:0]    memwb_result_i;

  logic               load_use_stall_o;
  logic               ex_valid_o;
  logic [XLEN-1:0]    ex_pc_o;
  logic [XLEN-1:0]    alu_a_o;
  logic [XLEN-1:0]    alu_b_o;
  logic [3:0]         alu_op_o;
  logic [XLEN-1:0]    ex_store_data_o;
  logic [RADDR_W-1:0] ex_rd_o;
  logic               ex_reg_write_o;
  logic               ex_mem_read_o;
  logic               ex_mem_write_o;

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_pc_i, id_rs_val_i, id_rt_val_i, id_imm_i,
           id_shamt_i, id_rs_i, id_rt_i, id_rd_i, id_alu_op_i, id_use_imm_i,
           id_use_shamt_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
           memwb_reg_write_i, memwb_rd_i, memwb_result_i,
    output load_use_stall_o, ex_valid_o, ex_pc_o, alu_a_o, alu_b_o, alu_op_o,
           ex_store_data_o, ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o
  );

  modport master (
    output stall_i, flush_i, id_valid_i, id_pc_i, id_rs_val_i, id_rt_val_i, id_imm_i,
           id_shamt_i, id_rs_i, id_rt_i, id_rd_i, id_alu_op_i, id_use_imm_i,
           id_use_shamt_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
           memwb_reg_write_i, memwb_rd_i, memwb_result_i,
    input  load_use_stall_o, ex_valid_o, ex_pc_o, alu_a_o, alu_b_o, alu_op_o,
           ex_store_data_o, ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats the register-file value.
// Without ID_EX_FWD_EN the register-file value passes straight through.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [RADDR_W-1:0] src,
  input  logic [XLEN-1:0]    rf_val,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    val
);

`ifdef ID_EX_FWD_EN
  always_comb begin
    if (writer_hits(exmem_reg_write, exmem_rd, src)) begin
      val = exmem_result;
    end else if (writer_hits(memwb_reg_write, memwb_rd, src)) begin
      val = memwb_result;
    end else begin
      val = rf_val;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{src, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
  assign val        = rf_val;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand select, forwarding and
// load-use bubble insertion. Forwarding is enabled by defining ID_EX_FWD_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  ex_reg_t         ex_q;
  ex_reg_t         ex_d;
  logic            ex_writer;
  logic            load_use;
  logic [XLEN-1:0] fwd_rs;
  logic [XLEN-1:0] fwd_rt;

  // Without forwarding every EX writer is a hazard, not just a load.
`ifdef ID_EX_FWD_EN
  assign ex_writer = ex_q.ctrl.mem_read;
`else
  assign ex_writer = ex_q.ctrl.mem_read | ex_q.ctrl.reg_write;
`endif

  assign load_use = ex_q.valid && bus.id_valid_i &&
                    (writer_hits(ex_writer, ex_q.rd, bus.id_rs_i) ||
                     writer_hits(ex_writer, ex_q.rd, bus.id_rt_i));

  always_comb begin
    // NOTE: hold is assigned first so every path drives ex_d and no latch is inferred.
    ex_d = ex_q;
    if (bus.flush_i) begin
      ex_d = EX_BUBBLE;
    end else if (bus.stall_i) begin
      ex_d = ex_q;
    end else if (load_use || !bus.id_valid_i) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d = '{valid:     1'b1,
               pc:        bus.id_pc_i,
               rs_val:    bus.id_rs_val_i,
               rt_val:    bus.id_rt_val_i,
               imm:       bus.id_imm_i,
               shamt:     bus.id_shamt_i,
               rs:        bus.id_rs_i,
               rt:        bus.id_rt_i,
               rd:        bus.id_rd_i,
               alu_op:    bus.id_alu_op_i,
               use_imm:   bus.id_use_imm_i,
               use_shamt: bus.id_use_shamt_i,
               ctrl:      '{reg_write: bus.id_reg_write_i,
                            mem_read:  bus.id_mem_read_i,
                            mem_write: bus.id_mem_write_i}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  id_ex_stage_fwd_mux u_fwd_rs (
    .src             (ex_q.rs),
    .rf_val          (ex_q.rs_val),
    .exmem_reg_write (bus.exmem_reg_write_i),
    .exmem_rd        (bus.exmem_rd_i),
    .exmem_result    (bus.exmem_result_i),
    .memwb_reg_write (bus.memwb_reg_write_i),
    .memwb_rd        (bus.memwb_rd_i),
    .memwb_result    (bus.memwb_result_i),
    .val             (fwd_rs)
  );

  id_ex_stage_fwd_mux u_fwd_rt (
    .src             (ex_q.rt),
    .rf_val          (ex_q.rt_val),
    .exmem_reg_write (bus.exmem_reg_write_i),
    .exmem_rd        (bus.exmem_rd_i),
    .exmem_result    (bus.exmem_result_i),
    .memwb_reg_write (bus.memwb_reg_write_i),
    .memwb_rd        (bus.memwb_rd_i),
    .memwb_result    (bus.memwb_result_i),
    .val             (fwd_rt)
  );

  assign bus.load_use_stall_o = load_use;
  assign bus.ex_valid_o       = ex_q.valid;
  assign bus.ex_pc_o          = ex_q.pc;
  assign bus.alu_a_o          = ex_q.use_shamt ? {{(XLEN-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign bus.alu_b_o          = ex_q.use_imm ? ex_q.imm : fwd_rt;
  assign bus.alu_op_o         = ex_q.alu_op;
  assign bus.ex_store_data_o  = fwd_rt;
  assign bus.ex_rd_o          = ex_q.rd;
  assign bus.ex_reg_write_o   = ex_q.valid & ex_q.ctrl.reg_write;
  assign bus.ex_mem_read_o    = ex_q.valid & ex_q.ctrl.mem_read;
  assign bus.ex_mem_write_o   = ex_q.valid & ex_q.ctrl.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver queues hand-computed expectations,
// a monitor pops and compares them at each falling edge or reset probe.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs_val, rt_val, imm;
    logic [4:0]  shamt, rs, rt, rd;
    logic [3:0]  op;
    logic        use_imm, use_shamt, rw, mr, mw;
  } id_t;

  typedef struct {
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } fwd_t;

  typedef struct {
    int          idx;
    logic        valid;
    logic [31:0] pc, a, b, sd;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw, lus;
  } exp_t;

  typedef struct {
    id_t  id;
    logic stall, flush;
    fwd_t fwd;
    exp_t exp;
  } cyc_t;

  logic   clk;
  logic   rst_n;
  int     n_cmp;
  int     n_err;
  cyc_t   cycs[$];
  exp_t   exp_q[$];
  event   probe_ev;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic id_t mk_id(input logic [31:0] pc, input logic [3:0] op,
                                input logic [4:0] rs, input logic [31:0] rs_val,
                                input logic [4:0] rt, input logic [31:0] rt_val,
                                input logic [4:0] rd, input logic rw);
    id_t i;
    i = '{valid: 1'b1, pc: pc, rs_val: rs_val, rt_val: rt_val, imm: 32'h0,
          shamt: 5'd0, rs: rs, rt: rt, rd: rd, op: op,
          use_imm: 1'b0, use_shamt: 1'b0, rw: rw, mr: 1'b0, mw: 1'b0};
    return i;
  endfunction

  function automatic id_t idle_id();
    id_t i;
    i = mk_id(32'h0, 4'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
    i.valid = 1'b0;
    return i;
  endfunction

  function automatic fwd_t mk_fwd(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                                  input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    fwd_t f;
    f = '{xw: xw, xrd: xrd, xres: xres, ww: ww, wrd: wrd, wres: wres};
    return f;
  endfunction

  function automatic exp_t mk_exp(input int idx, input logic [31:0] pc, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                                  input logic [4:0] rd, input logic rw, input logic mr,
                                  input logic mw, input logic lus);
    exp_t e;
    e = '{idx: idx, valid: 1'b1, pc: pc, a: a, b: b, sd: sd, op: op, rd: rd,
          rw: rw, mr: mr, mw: mw, lus: lus};
    return e;
  endfunction

  function automatic exp_t bubble_exp(input int idx, input logic lus);
    exp_t e;
    e = mk_exp(idx, 32'h0, ALU_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, lus);
    e.valid = 1'b0;
    return e;
  endfunction

  task automatic add(input id_t id, input logic stall, input logic flush,
                     input fwd_t fwd, input exp_t exp);
    cyc_t c;
    c.id = id; c.stall = stall; c.flush = flush; c.fwd = fwd; c.exp = exp;
    cycs.push_back(c);
  endtask

  task automatic build_table();
    fwd_t nf;
    id_t  i;
    exp_t e7;
    nf = mk_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    // Plain ADD, no hazards.
    i = mk_id(32'h100, ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd4, 1'b1);
    add(i, 1'b0, 1'b0, nf, mk_exp(0, 32'h100, ALU_ADD, 32'd5, 32'd7, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    // Both stages match rs: EX/MEM wins.
    i = mk_id(32'h104, ALU_SUB, 5'd1, 32'd5, 5'd2, 32'd7, 5'd5, 1'b1);
    add(i, 1'b0, 1'b0, mk_fwd(1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20),
        mk_exp(1, 32'h104, ALU_SUB, FWD ? 32'h10 : 32'd5, 32'd7, 32'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    // Writers to register 0 are never forwarded.
    i = mk_id(32'h108, ALU_SUB, 5'd1, 32'd5, 5'd2, 32'd7, 5'd6, 1'b1);
    add(i, 1'b0, 1'b0, mk_fwd(1'b1, 5'd0, 32'h10, 1'b1, 5'd0, 32'h20),
        mk_exp(2, 32'h108, ALU_SUB, 32'd5, 32'd7, 32'd7, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
    // MEM/WB-only match on rt feeds both ALU B and store data.
    i = mk_id(32'h10C, ALU_OR, 5'd1, 32'd5, 5'd2, 32'd7, 5'd7, 1'b1);
    add(i, 1'b0, 1'b0, mk_fwd(1'b1, 5'd9, 32'h99, 1'b1, 5'd2, 32'h33),
        mk_exp(3, 32'h10C, ALU_OR, 32'd5, FWD ? 32'h33 : 32'd7, FWD ? 32'h33 : 32'd7,
               5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    // LW r3; the next instruction reads r3 -> load-use stall.
    i = mk_id(32'h110, ALU_ADD, 5'd8, 32'h1000, 5'd3, 32'h33, 5'd3, 1'b1);
    i.imm = 32'd4; i.use_imm = 1'b1; i.mr = 1'b1;
    add(i, 1'b0, 1'b0, nf, mk_exp(4, 32'h110, ALU_ADD, 32'h1000, 32'd4, 32'h33, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1));
    i = mk_id(32'h114, ALU_ADD, 5'd3, 32'h11, 5'd2, 32'd7, 5'd9, 1'b1);
    add(i, 1'b0, 1'b0, nf, bubble_exp(5, 1'b0));
    add(i, 1'b0, 1'b0, mk_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hBEEF),
        mk_exp(6, 32'h114, ALU_ADD, FWD ? 32'hBEEF : 32'h11, 32'd7, 32'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0));
    // Three stalled edges with changing ID inputs, then flush during stall.
    i = mk_id(32'h118, ALU_AND, 5'd1, 32'd5, 5'd2, 32'd7, 5'd10, 1'b1);
    e7 = mk_exp(7, 32'h118, ALU_AND, 32'd5, 32'd7, 32'd7, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    add(i, 1'b0, 1'b0, nf, e7);
    e7.idx = 8;
    add(mk_id(32'h11C, ALU_XOR, 5'd9, 32'h99, 5'd2, 32'd7, 5'd11, 1'b1), 1'b1, 1'b0, nf, e7);
    e7.idx = 9;
    add(mk_id(32'h120, ALU_NOR, 5'd4, 32'h44, 5'd5, 32'h55, 5'd12, 1'b1), 1'b1, 1'b0, nf, e7);
    e7.idx = 10;
    add(mk_id(32'h124, ALU_SLT, 5'd6, 32'h66, 5'd7, 32'h77, 5'd13, 1'b1), 1'b1, 1'b0, nf, e7);
    add(mk_id(32'h128, ALU_SLTU, 5'd8, 32'h88, 5'd9, 32'h99, 5'd14, 1'b1), 1'b1, 1'b1, nf, bubble_exp(11, 1'b0));
    // SLL uses zero-extended shamt for A.
    i = mk_id(32'h12C, ALU_SLL, 5'd0, 32'h0, 5'd2, 32'd7, 5'd13, 1'b1);
    i.shamt = 5'd4; i.use_shamt = 1'b1;
    add(i, 1'b0, 1'b0, nf, mk_exp(12, 32'h12C, ALU_SLL, 32'd4, 32'd7, 32'd7, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0));
    // SW with all-ones immediate; store data still takes the forwarded rt.
    i = mk_id(32'h130, ALU_ADD, 5'd1, 32'd5, 5'd14, 32'h1234, 5'd0, 1'b0);
    i.imm = 32'hFFFF_FFFF; i.use_imm = 1'b1; i.mw = 1'b1;
    add(i, 1'b0, 1'b0, mk_fwd(1'b1, 5'd14, 32'hCAFE, 1'b0, 5'd0, 32'h0),
        mk_exp(13, 32'h130, ALU_ADD, 32'd5, 32'hFFFF_FFFF, FWD ? 32'hCAFE : 32'h1234,
               5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    // Non-load writer followed by a reader: hazard only without forwarding; flush wins anyway.
    i = mk_id(32'h134, ALU_OR, 5'd1, 32'd5, 5'd2, 32'd7, 5'd15, 1'b1);
    add(i, 1'b0, 1'b0, nf, mk_exp(14, 32'h134, ALU_OR, 32'd5, 32'd7, 32'd7, 5'd15, 1'b1, 1'b0, 1'b0, !FWD));
    add(mk_id(32'h138, ALU_AND, 5'd15, 32'h15, 5'd2, 32'd7, 5'd16, 1'b1), 1'b0, 1'b1, nf, bubble_exp(15, 1'b0));
    i = mk_id(32'h13C, ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd17, 1'b1);
    add(i, 1'b0, 1'b0, nf, mk_exp(16, 32'h13C, ALU_ADD, 32'd5, 32'd7, 32'd7, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic drive_id(input id_t i, input logic stall, input logic flush);
    bus.stall_i        = stall;
    bus.flush_i        = flush;
    bus.id_valid_i     = i.valid;
    bus.id_pc_i        = i.pc;
    bus.id_rs_val_i    = i.rs_val;
    bus.id_rt_val_i    = i.rt_val;
    bus.id_imm_i       = i.imm;
    bus.id_shamt_i     = i.shamt;
    bus.id_rs_i        = i.rs;
    bus.id_rt_i        = i.rt;
    bus.id_rd_i        = i.rd;
    bus.id_alu_op_i    = i.op;
    bus.id_use_imm_i   = i.use_imm;
    bus.id_use_shamt_i = i.use_shamt;
    bus.id_reg_write_i = i.rw;
    bus.id_mem_read_i  = i.mr;
    bus.id_mem_write_i = i.mw;
  endtask

  task automatic drive_fwd(input fwd_t f);
    bus.exmem_reg_write_i = f.xw;
    bus.exmem_rd_i        = f.xrd;
    bus.exmem_result_i    = f.xres;
    bus.memwb_reg_write_i = f.ww;
    bus.memwb_rd_i        = f.wrd;
    bus.memwb_result_i    = f.wres;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    string p;
    p = $sformatf("c%0d", e.idx);
    check({p, ".ex_valid"},   32'(bus.ex_valid_o),       32'(e.valid));
    check({p, ".ex_pc"},      bus.ex_pc_o,               e.pc);
    check({p, ".alu_a"},      bus.alu_a_o,               e.a);
    check({p, ".alu_b"},      bus.alu_b_o,               e.b);
    check({p, ".alu_op"},     32'(bus.alu_op_o),         32'(e.op));
    check({p, ".store_data"}, bus.ex_store_data_o,       e.sd);
    check({p, ".ex_rd"},      32'(bus.ex_rd_o),          32'(e.rd));
    check({p, ".reg_write"},  32'(bus.ex_reg_write_o),   32'(e.rw));
    check({p, ".mem_read"},   32'(bus.ex_mem_read_o),    32'(e.mr));
    check({p, ".mem_write"},  32'(bus.ex_mem_write_o),   32'(e.mw));
    check({p, ".load_use"},   32'(bus.load_use_stall_o), 32'(e.lus));
  endtask

  // Monitor: one expectation per falling edge, or immediately on a reset probe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or probe_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  end

  task automatic probe_now(input exp_t e);
    exp_q.push_back(e);
    -> probe_ev;
  endtask

  initial begin
    fwd_t nf;
    id_t  add3;
    n_cmp = 0;
    n_err = 0;
    nf    = mk_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    build_table();
    rst_n = 1'b1;
    drive_id(idle_id(), 1'b0, 1'b0);
    drive_fwd(nf);
    #1 rst_n = 1'b0;
    #2 probe_now(bubble_exp(-1, 1'b0));
    #10 rst_n = 1'b1;
    drive_id(cycs[0].id, cycs[0].stall, cycs[0].flush);

    for (int k = 0; k < cycs.size(); k++) begin
      @(posedge clk);
      #1;
      if (k + 1 < cycs.size()) drive_id(cycs[k+1].id, cycs[k+1].stall, cycs[k+1].flush);
      else                     drive_id(idle_id(), 1'b0, 1'b0);
      drive_fwd(cycs[k].fwd);
      exp_q.push_back(cycs[k].exp);
    end

    // Asynchronous reset between edges, held across an edge, then released.
    add3 = mk_id(32'h140, ALU_SUB, 5'd2, 32'd7, 5'd1, 32'd5, 5'd18, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive_id(add3, 1'b0, 1'b0);
    drive_fwd(nf);
    #1 probe_now(bubble_exp(100, 1'b0));
    @(posedge clk);
    #1 exp_q.push_back(bubble_exp(101, 1'b0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_id(idle_id(), 1'b0, 1'b0);
    exp_q.push_back(mk_exp(102, 32'h140, ALU_SUB, 32'd7, 32'd5, 32'd5, 5'd18, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    #1;
    check("drain.pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
